// File: rtl/board_io_ctrl.sv
`timescale 1ns/1ps
// Board user-I/O controller: syncs and debounces DIP switches, drives LEDs from a selectable source.
// Latency: switch to sw_deb is DB_CYCLES+2 cycles, a config write reaches led 2 cycles later; no backpressure.
module board_io_ctrl #(
  parameter int NSW            = 8,
  parameter int NLED           = 16,
  parameter int DB_CYCLES      = 1000,
  parameter int HB_DIV         = 50000000,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic            sys0_clk,
  input  logic            sys0_rstn,
  input  logic [NSW-1:0]  usr_sw_i,
  input  logic [NLED-1:0] status_i,
  input  logic            cfg_wr_en,
  input  logic            cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic [NSW-1:0]  sw_deb,
  output logic            sw_chg,
  output logic [NLED-1:0] led
);

  localparam int CW  = $clog2(DB_CYCLES);
  localparam int HBW = $clog2(HB_DIV);
  localparam int NSL = (NSW < NLED) ? NSW : NLED;
  localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [HBW-1:0]  HB_LAST = HBW'(HB_DIV - 1);
  localparam logic [NLED-1:0] LED_POL = {NLED{LED_ACTIVE_LOW}};

  logic [NSW-1:0]         sw_meta_q, sw_meta_d;
  logic [NSW-1:0]         sw_sync_q, sw_sync_d;
  logic [NSW-1:0]         sw_deb_q, sw_deb_d;
  logic [NSW-1:0][CW-1:0] db_cnt_q, db_cnt_d;
  logic                   sw_chg_q, sw_chg_d;
  logic [HBW-1:0]         hb_cnt_q, hb_cnt_d;
  logic                   hb_q, hb_d;
  logic [NLED-1:0]        tick_cnt_q, tick_cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic [NLED-1:0]        user_reg_q, user_reg_d;
  logic [31:0]            cfg_rdata_q, cfg_rdata_d;
  logic [NLED-1:0]        led_q, led_d;

  logic [15:0]     sw_ext16;
  logic [31:0]     user_ext32;
  logic [NLED-1:0] sw_led;
  logic [NLED-1:0] status_hb;
  logic [NLED-1:0] led_src;
  logic            unused_bits;

  assign unused_bits = ^{cfg_wdata, status_i[0]};

  // Each bit restarts its count whenever the synced level agrees with the accepted one.
  always_comb begin
    sw_meta_d = usr_sw_i;
    sw_sync_d = sw_meta_q;
    sw_deb_d  = sw_deb_q;
    db_cnt_d  = '0;
    for (int i = 0; i < NSW; i++) begin
      if (sw_sync_q[i] != sw_deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          sw_deb_d[i] = sw_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    sw_chg_d = |(sw_deb_d ^ sw_deb_q);
  end

  always_comb begin
    hb_cnt_d   = hb_cnt_q + 1'b1;
    hb_d       = hb_q;
    tick_cnt_d = tick_cnt_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d   = '0;
      hb_d       = ~hb_q;
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    user_reg_d = user_reg_q;
    if (cfg_wr_en) begin
      if (cfg_addr) begin
        user_reg_d = cfg_wdata[NLED-1:0];
      end else begin
        mode_d = cfg_wdata[1:0];
      end
    end
    sw_ext16               = '0;
    sw_ext16[NSW-1:0]      = sw_deb_q;
    user_ext32             = '0;
    user_ext32[NLED-1:0]   = user_reg_q;
    cfg_rdata_d = cfg_addr ? user_ext32 : {sw_ext16, 14'b0, mode_q};
  end

  always_comb begin
    sw_led            = '0;
    sw_led[NSL-1:0]   = sw_deb_q[NSL-1:0];
    status_hb         = status_i;
    status_hb[0]      = hb_q;
    case (mode_q)
      2'd0:    led_src = user_reg_q;
      2'd1:    led_src = sw_led;
      2'd2:    led_src = status_hb;
      default: led_src = tick_cnt_q;
    endcase
    led_d = led_src ^ LED_POL;
  end

  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_deb_q    <= '0;
      db_cnt_q    <= '0;
      sw_chg_q    <= 1'b0;
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
      tick_cnt_q  <= '0;
      mode_q      <= 2'd0;
      user_reg_q  <= '0;
      cfg_rdata_q <= '0;
      led_q       <= LED_POL;
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      sw_deb_q    <= sw_deb_d;
      db_cnt_q    <= db_cnt_d;
      sw_chg_q    <= sw_chg_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
      tick_cnt_q  <= tick_cnt_d;
      mode_q      <= mode_d;
      user_reg_q  <= user_reg_d;
      cfg_rdata_q <= cfg_rdata_d;
      led_q       <= led_d;
    end
  end

  assign sw_deb    = sw_deb_q;
  assign sw_chg    = sw_chg_q;
  assign cfg_rdata = cfg_rdata_q;
  assign led       = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
`timescale 1ns/1ps
// Directed bench for board_io_ctrl: main instance plus a narrow active-low instance for the wrap and polarity cases.
module tb_board_io_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [7:0]  usr_sw;
  logic [15:0] status;
  logic        wr_en, addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  deb;
  logic        chg;
  logic [15:0] led;

  logic        b_wr_en, b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_status, b_led;
  logic [7:0]  b_deb;
  logic        b_chg;

  board_io_ctrl #(.NSW(8), .NLED(16), .DB_CYCLES(4), .HB_DIV(5), .LED_ACTIVE_LOW(1'b0)) dut (
    .sys0_clk(clk), .sys0_rstn(rstn), .usr_sw_i(usr_sw), .status_i(status),
    .cfg_wr_en(wr_en), .cfg_addr(addr), .cfg_wdata(wdata), .cfg_rdata(rdata),
    .sw_deb(deb), .sw_chg(chg), .led(led)
  );

  board_io_ctrl #(.NSW(8), .NLED(4), .DB_CYCLES(4), .HB_DIV(2), .LED_ACTIVE_LOW(1'b1)) dut_b (
    .sys0_clk(clk), .sys0_rstn(rstn), .usr_sw_i(usr_sw), .status_i(b_status),
    .cfg_wr_en(b_wr_en), .cfg_addr(b_addr), .cfg_wdata(b_wdata), .cfg_rdata(b_rdata),
    .sw_deb(b_deb), .sw_chg(b_chg), .led(b_led)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic [31:0] user_wd;
    logic [31:0] ctrl_wd;
    logic [7:0]  sw;
    logic [15:0] exp_led;
    logic [31:0] exp_ctrl;
    logic [31:0] exp_user;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first, pulses, found, bad, wrap;
    logic [15:0] prev, v, exp16;
    logic [3:0]  bprev, act4, exp4;

    vecs[0] = '{32'h0000_A5C3, 32'h0000_0000, 8'h00, 16'hA5C3, 32'h0000_0000, 32'h0000_A5C3};
    vecs[1] = '{32'h0000_1234, 32'h0000_0001, 8'h3C, 16'h003C, 32'h003C_0001, 32'h0000_1234};
    vecs[2] = '{32'h0000_FFFF, 32'h0000_0000, 8'hFF, 16'hFFFF, 32'h00FF_0000, 32'h0000_FFFF};
    vecs[3] = '{32'h0001_5A5A, 32'hFFFF_FFFC, 8'h81, 16'h5A5A, 32'h0081_0000, 32'h0000_5A5A};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFD, 8'h81, 16'h0081, 32'h0081_0001, 32'h0000_0000};

    rstn = 1'b0; usr_sw = 8'h00; status = 16'h0000;
    wr_en = 1'b0; addr = 1'b0; wdata = '0;
    b_wr_en = 1'b0; b_addr = 1'b0; b_wdata = '0; b_status = 4'h0;

    #12;
    check("rst_led", led, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_deb", deb, 32'h0);
    check("rst_chg", chg, 32'h0);
    check("rst_led_active_low", b_led, 32'hF);
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc(2);

    // USER write in cycle k with a same-cycle read of address 1
    wr_en = 1'b1; addr = 1'b1; wdata = 32'h0000_A5C3;
    cyc(1);
    wr_en = 1'b0;
    check("user_rd_k1", rdata, 32'h0);
    check("user_led_k1", led, 32'h0);
    cyc(1);
    check("user_rd_k2", rdata, 32'h0000_A5C3);
    check("user_led_k2", led, 32'h0000_A5C3);

    // Debounce accept: deb and a single pulse 6 edges after the raw change
    usr_sw = 8'h81; first = 0; pulses = 0;
    for (int n = 1; n <= 10; n++) begin
      cyc(1);
      if (chg) pulses++;
      if (deb == 8'h81 && first == 0) first = n;
    end
    check("deb_accept_cycle", first, 6);
    check("deb_accept_pulses", pulses, 1);
    check("deb_accept_value", deb, 32'h81);

    // Three-cycle glitch must be rejected
    usr_sw = 8'h01; pulses = 0; bad = 0;
    for (int n = 1; n <= 15; n++) begin
      cyc(1);
      if (n == 3) usr_sw = 8'h81;
      if (chg) pulses++;
      if (deb != 8'h81) bad++;
    end
    check("glitch_pulses", pulses, 0);
    check("glitch_deb_moves", bad, 0);

    for (int i = 0; i < 5; i++) begin
      usr_sw = vecs[i].sw;
      wr(1'b1, vecs[i].user_wd);
      wr(1'b0, vecs[i].ctrl_wd);
      cyc(12);
      check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      addr = 1'b0;
      cyc(1);
      check($sformatf("vec%0d_ctrl_rd", i), rdata, vecs[i].exp_ctrl);
      addr = 1'b1;
      cyc(1);
      check($sformatf("vec%0d_user_rd", i), rdata, vecs[i].exp_user);
    end

    // STATUS mode: bit 0 follows the heartbeat, 10-cycle period
    status = 16'hFFFE;
    wr(1'b0, 32'h2);
    cyc(2);
    prev = led; found = 0;
    for (int n = 0; n < 12 && found == 0; n++) begin
      cyc(1);
      if (led != prev) found = 1;
    end
    check("hb_edge_found", found, 1);
    v = led;
    check("hb_level", v & 16'hFFFE, 32'hFFFE);
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      exp16 = (((i / 5) % 2) == 1) ? (v ^ 16'h0001) : v;
      check("hb_wave", led, exp16);
    end

    // Asynchronous reset in the middle of a cycle, switches held closed
    addr = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    check("midrst_led", led, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_deb", deb, 32'h0);
    check("midrst_chg", chg, 32'h0);
    check("midrst_led_active_low", b_led, 32'hF);
    cyc(2);
    rstn = 1'b1;
    wr_en = 1'b1; addr = 1'b0; wdata = 32'h3;
    first = 0; pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      cyc(1);
      if (n == 1) wr_en = 1'b0;
      if (chg) pulses++;
      if (deb == 8'h81 && first == 0) first = n;
      if (n >= 2) check($sformatf("count_led_c%0d", n), led, (n - 1) / 5);
    end
    check("closed_at_reset_cycle", first, 6);
    check("closed_at_reset_pulses", pulses, 1);

    // Narrow active-low instance: tick_cnt wraps all-ones to zero
    b_wr_en = 1'b1; b_addr = 1'b0; b_wdata = 32'h3;
    cyc(1);
    b_wr_en = 1'b0;
    cyc(2);
    wrap = 0;
    for (int n = 0; n < 40; n++) begin
      bprev = b_led;
      cyc(1);
      if (b_led != bprev) begin
        act4 = ~b_led;
        exp4 = ~bprev + 4'd1;
        check("b_count_step", act4, exp4);
        if (bprev == 4'h0 && b_led == 4'hF) wrap = 1;
      end
    end
    check("b_tick_wrap_seen", wrap, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
